// File: rtl/upsample2x_streamer_pkg.sv
// Shared constants for the U-Net accelerator blocks: pixel/dimension widths,
// upsampler FSM state encoding and a dimension clamp helper.
package upsample2x_streamer_pkg;

   localparam int PIX_W = 8;
   localparam int DIM_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [DIM_W-1:0] dim_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROW_A = 2'd1;
   localparam logic [1:0] ST_ROW_B = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic dim_t clamp_dim(input dim_t value, input dim_t limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/upsample2x_streamer_if.sv
// Control, input-stream and output-stream signals of the 2x upsampler.
// master = the surrounding controller/source/sink, slave = the upsampler.
interface upsample2x_streamer_if;
   import upsample2x_streamer_pkg::*;

   logic   start;
   dim_t   stage_width;
   dim_t   stage_height;
   pixel_t pixel_in;
   logic   in_valid;
   logic   in_ready;
   pixel_t pixel_out;
   logic   out_valid;
   logic   out_ready;
   logic   out_last;
   logic   busy;
   logic   frame_done;

   modport master (
      output start, stage_width, stage_height, pixel_in, in_valid, out_ready,
      input  in_ready, pixel_out, out_valid, out_last, busy, frame_done
   );

   modport slave (
      input  start, stage_width, stage_height, pixel_in, in_valid, out_ready,
      output in_ready, pixel_out, out_valid, out_last, busy, frame_done
   );

endinterface

// File: rtl/upsample2x_streamer_linebuf.sv
// Single-row line buffer: one synchronous write port, one combinational
// read port, so the replay row can be presented without a read bubble.
module upsample_linebuf
   import upsample2x_streamer_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  pixel_t        wdata,
   input  logic [AW-1:0] raddr,
   output pixel_t        rdata
);

   pixel_t mem [DEPTH];

   // NOTE: storage arrays take no reset; every entry is written in ROW_A
   // before ROW_B reads it, and a reset term would block RAM/array mapping.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/upsample2x_streamer.sv
// Nearest-neighbour 2x upsampler: each pixel is emitted twice, and each row is
// emitted live (ROW_A) and then replayed from the line buffer (ROW_B).
module upsample2x_streamer
   import upsample2x_streamer_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128
) (
   input logic                  clk,
   input logic                  rst_n,
   upsample2x_streamer_if.slave bus
);

   localparam int   COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam dim_t MAX_W = dim_t'(IMAGE_WIDTH);
   localparam dim_t MAX_H = dim_t'(IMAGE_HEIGHT);

   logic [1:0]       state;
   dim_t             width_q;
   dim_t             height_q;
   dim_t             row;
   logic [COL_W-1:0] col;
   logic             dup;
   pixel_t           pixel_q;
   logic             valid_q;
   logic             last_q;
   logic             done_q;

   pixel_t rd_pixel;
   logic   slot_free;
   logic   accept;
   logic   in_xfer;
   logic   last_col;
   logic   last_row;

   // NOTE: every signal is assigned on every pass through this block, so no
   // latch can be inferred.
   always_comb begin
      slot_free = !valid_q || bus.out_ready;
      accept    = (state == ST_ROW_A) && !dup && slot_free;
      in_xfer   = accept && bus.in_valid;
      last_col  = (dim_t'(col) == width_q - dim_t'(1));
      last_row  = (row == height_q - dim_t'(1));
   end

   upsample_linebuf #(
      .DEPTH (IMAGE_WIDTH),
      .AW    (COL_W)
   ) u_linebuf (
      .clk   (clk),
      .we    (in_xfer),
      .waddr (col),
      .wdata (bus.pixel_in),
      .raddr (col),
      .rdata (rd_pixel)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         width_q  <= '0;
         height_q <= '0;
         row      <= '0;
         col      <= '0;
         dup      <= 1'b0;
         pixel_q  <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start && (bus.stage_width != '0) && (bus.stage_height != '0)) begin
                  width_q  <= clamp_dim(bus.stage_width, MAX_W);
                  height_q <= clamp_dim(bus.stage_height, MAX_H);
                  row      <= '0;
                  col      <= '0;
                  dup      <= 1'b0;
                  state    <= ST_ROW_A;
               end
            end

            ST_ROW_A, ST_ROW_B: begin
               if (slot_free) begin
                  if (dup) begin
                     // Second copy; the row/frame advance happens as it is
                     // presented, and the next state only moves once it drains.
                     valid_q <= 1'b1;
                     last_q  <= last_col;
                     dup     <= 1'b0;
                     if (last_col) begin
                        col <= '0;
                        if (state == ST_ROW_A) begin
                           state <= ST_ROW_B;
                        end else if (last_row) begin
                           state <= ST_DONE;
                        end else begin
                           row   <= row + dim_t'(1);
                           state <= ST_ROW_A;
                        end
                     end else begin
                        col <= col + COL_W'(1);
                     end
                  end else if (state == ST_ROW_B) begin
                     pixel_q <= rd_pixel;
                     valid_q <= 1'b1;
                     last_q  <= 1'b0;
                     dup     <= 1'b1;
                  end else if (bus.in_valid) begin
                     pixel_q <= bus.pixel_in;
                     valid_q <= 1'b1;
                     last_q  <= 1'b0;
                     dup     <= 1'b1;
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                  end
               end
            end

            ST_DONE: begin
               if (slot_free) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = accept;
   assign bus.pixel_out  = pixel_q;
   assign bus.out_valid  = valid_q;
   assign bus.out_last   = last_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_upsample2x_streamer.sv
// Self-checking bench for upsample2x_streamer: directed frame table, corner
// sequences, and randomized frames checked against a row/column replay model.
module tb_upsample2x_streamer;
   import upsample2x_streamer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   upsample2x_streamer_if bus ();

   upsample2x_streamer #(
      .IMAGE_WIDTH  (128),
      .IMAGE_HEIGHT (128)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] img   [$];
   logic [7:0] img_q [$];
   logic [7:0] exp_q [$];

   typedef struct packed {
      logic [7:0]   w;
      logic [7:0]   h;
      logic [1:0]   mode;
      logic [31:0]  pix;
      logic [127:0] expv;
      logic [7:0]   n_exp;
   } vec_t;

   vec_t vecs [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.start        = 1'b0;
      bus.stage_width  = '0;
      bus.stage_height = '0;
      bus.pixel_in     = '0;
      bus.in_valid     = 1'b0;
      bus.out_ready    = 1'b1;
   endtask

   // Reference: row r is emitted twice, every pixel of it twice.
   task automatic build_expected(input int w, input int h);
      exp_q.delete();
      for (int r = 0; r < h; r++)
         for (int rep = 0; rep < 2; rep++)
            for (int c = 0; c < w; c++)
               for (int k = 0; k < 2; k++)
                  exp_q.push_back(img[r*w + c]);
      img_q = img;
   endtask

   // mode 0: ready always; 1: ready 1,0,0 pattern plus a start pulse while busy;
   // 2: random ready and random input gaps.
   task automatic run_frame(input int wp, input int hp, input int w, input int h, input int mode);
      int         n_out = 0;
      int         n_done = 0;
      int         total = 4*w*h;
      logic       stall = 1'b0;
      logic [7:0] hold_pix = '0;
      logic       hold_last = 1'b0;
      logic [7:0] e;
      bus.stage_width  = 8'(wp);
      bus.stage_height = 8'(hp);
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_on_start", 32'(bus.busy), 1);
      for (int cyc = 0; cyc < 6000 && n_done == 0; cyc++) begin
         bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         bus.in_valid  = (img_q.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
         bus.pixel_in  = (img_q.size() > 0) ? img_q[0] : 8'($urandom);
         bus.start     = (mode == 1 && cyc == 4);
         if (bus.start) begin
            bus.stage_width  = 8'd1;
            bus.stage_height = 8'd1;
         end
         #1;
         if (bus.start) check("busy_ignore_start", 32'(bus.busy), 1);
         if (stall) begin
            check("stall_pixel", 32'(bus.pixel_out), 32'(hold_pix));
            check("stall_last", 32'(bus.out_last), 32'(hold_last));
         end
         if (bus.out_valid && !bus.out_ready) check("in_ready_when_full", 32'(bus.in_ready), 0);
         if (bus.frame_done) begin
            n_done++;
            check("outputs_at_done", n_out, total);
            check("busy_at_done", 32'(bus.busy), 0);
         end
         if (bus.in_valid && bus.in_ready) void'(img_q.pop_front());
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_output", n_out + 1, total);
            end else begin
               e = exp_q.pop_front();
               check("pixel", 32'(bus.pixel_out), 32'(e));
               check("out_last", 32'(bus.out_last), 32'((n_out % (2*w)) == 2*w - 1));
            end
            n_out++;
         end
         stall     = bus.out_valid && !bus.out_ready;
         hold_pix  = bus.pixel_out;
         hold_last = bus.out_last;
         @(posedge clk); #1;
      end
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (n_done == 0) check("frame_done_seen", n_done, 1);
      check("frame_done_pulse", 32'(bus.frame_done), 0);
      check("inputs_consumed", img_q.size(), 0);
   endtask

   initial begin
      int w;
      int h;
      int n_out;

      vecs[0] = '{w: 8'd2, h: 8'd2, mode: 2'd0,
                  pix: {8'd40, 8'd30, 8'd20, 8'd10},
                  expv: {8'd40, 8'd40, 8'd30, 8'd30, 8'd40, 8'd40, 8'd30, 8'd30,
                         8'd20, 8'd20, 8'd10, 8'd10, 8'd20, 8'd20, 8'd10, 8'd10},
                  n_exp: 8'd16};
      vecs[1] = vecs[0];
      vecs[1].mode = 2'd1;
      vecs[2] = '{w: 8'd1, h: 8'd3, mode: 2'd0,
                  pix: {8'd0, 8'd7, 8'd6, 8'd5},
                  expv: {32'd0, {4{8'd7}}, {4{8'd6}}, {4{8'd5}}},
                  n_exp: 8'd12};

      idle_inputs();
      #12;
      check("rst_pixel_out", 32'(bus.pixel_out), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_last", 32'(bus.out_last), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_frame_done", 32'(bus.frame_done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         img_q.delete();
         exp_q.delete();
         for (int p = 0; p < int'(vecs[i].w) * int'(vecs[i].h); p++)
            img_q.push_back(vecs[i].pix[8*p +: 8]);
         for (int p = 0; p < int'(vecs[i].n_exp); p++)
            exp_q.push_back(vecs[i].expv[8*p +: 8]);
         run_frame(vecs[i].w, vecs[i].h, vecs[i].w, vecs[i].h, int'(vecs[i].mode));
      end

      // start with a zero dimension is ignored
      bus.stage_width  = 8'd0;
      bus.stage_height = 8'd2;
      bus.in_valid     = 1'b1;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("zero_dim_busy", 32'(bus.busy), 0);
         check("zero_dim_in_ready", 32'(bus.in_ready), 0);
         check("zero_dim_frame_done", 32'(bus.frame_done), 0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;

      // reset in the replay row of a 4x4 frame
      img.delete();
      for (int p = 1; p <= 16; p++) img.push_back(8'(p));
      img_q = img;
      bus.stage_width  = 8'd4;
      bus.stage_height = 8'd4;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_out = 0;
      for (int cyc = 0; cyc < 200 && n_out < 11; cyc++) begin
         bus.in_valid = (img_q.size() > 0);
         bus.pixel_in = (img_q.size() > 0) ? img_q[0] : 8'd0;
         #1;
         if (bus.in_valid && bus.in_ready) void'(img_q.pop_front());
         if (bus.out_valid && bus.out_ready) n_out++;
         @(posedge clk); #1;
      end
      check("pre_reset_busy", 32'(bus.busy), 1);
      check("pre_reset_in_ready", 32'(bus.in_ready), 0);
      rst_n = 1'b0;
      #1;
      check("midrst_pixel_out", 32'(bus.pixel_out), 0);
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_out_last", 32'(bus.out_last), 0);
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_in_ready", 32'(bus.in_ready), 0);
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      img = '{8'd10, 8'd20, 8'd30, 8'd40};
      build_expected(2, 2);
      run_frame(2, 2, 2, 2, 0);

      // full-width ramp, then an over-wide request clamped to 128
      img.delete();
      for (int p = 0; p < 256; p++) img.push_back(8'(p));
      build_expected(128, 2);
      run_frame(128, 2, 128, 2, 0);

      img.delete();
      for (int p = 0; p < 128; p++) img.push_back(8'($urandom));
      build_expected(128, 1);
      run_frame(200, 1, 128, 1, 2);

      for (int t = 0; t < 8; t++) begin
         w = $urandom_range(1, 9);
         h = $urandom_range(1, 4);
         img.delete();
         for (int p = 0; p < w*h; p++) img.push_back(8'($urandom));
         build_expected(w, h);
         run_frame(w, h, w, h, 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/upsample2x_streamer.md
Name: upsample2x_streamer

Overview:
- Nearest-neighbour 2x upsampler for the U-Net decoder path; the inverse of the encoder-side maxpool2x2 reduction.
- Accepts an 8-bit feature-map stream of stage_width x stage_height pixels.
- Emits a (2*stage_width) x (2*stage_height) stream: each input pixel is repeated twice horizontally, and each row is replayed once from an internal line buffer.
- Sits between a decoder stage's pixel source and the next convolution stage's collector input.

Parameters:
- IMAGE_WIDTH, 128, maximum supported input row length and line-buffer depth.
- IMAGE_HEIGHT, 128, maximum supported input row count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- stage_width  input  8  input row length (1..IMAGE_WIDTH); latched on start.
- stage_height  input  8  input row count (1..IMAGE_HEIGHT); latched on start.
- pixel_in  input  8  input pixel.
- in_valid  input  1  pixel_in valid.
- in_ready  output  1  block accepts pixel_in this cycle.
- pixel_out  output  8  upsampled pixel.
- out_valid  output  1  pixel_out valid.
- out_ready  input  1  downstream accepts pixel_out.
- out_last  output  1  pixel_out is the last pixel of an output row.
- busy  output  1  high from the accepted start until frame_done.
- frame_done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all counters 0.
  - pixel_out=0, out_valid=0, out_last=0, in_ready=0, busy=0, frame_done=0.
  - Line-buffer contents are don't-care.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - pixel_out and out_last hold stable while out_valid && !out_ready.
- Output register: one stage. The slot is free when !out_valid || out_ready.
- State machine: IDLE, ROW_A, ROW_B, DONE.
- IDLE:
  - in_ready=0.
  - start with stage_width!=0 and stage_height!=0: latch both, row=0, col=0, dup=0, go to ROW_A, busy=1.
  - start with a zero dimension: ignored.
- ROW_A (live row):
  - in_ready = (dup==0) && slot free.
  - On an input transfer: pixel_out<=pixel_in, out_valid<=1, linebuf[col]<=pixel_in, dup<=1.
  - When dup==1 and slot free: re-present the same pixel (out_valid stays 1) and set dup<=0.
  - out_last=1 on the second copy when col==width-1.
  - On that handshake: col<=0, go to ROW_B.
  - Otherwise col increments after each second copy.
  - If no pixel arrives while the slot frees, out_valid<=0.
  - Latency: first copy visible the cycle after the input transfer.
  - Throughput: at most one input per 2 cycles.
- ROW_B (replay row):
  - in_ready=0.
  - When the slot is free: present linebuf[col] (combinational read of a register array) twice, same dup/col rules as ROW_A, no input needed.
  - On the last pixel: if row==height-1, go to DONE; else row++ and go to ROW_A.
- DONE:
  - Wait until the final output transfer completes.
  - Then out_valid=0, frame_done=1 for one cycle, busy=0, go to IDLE.
- Width rules:
  - Output column span is 2*stage_width (9 bits); output row count is 2*stage_height.
  - Values above the IMAGE_* limits are clamped to the limit when latched.
- Boundary conditions:
  - start while busy: ignored.
  - in_valid in IDLE/ROW_B/DONE: ignored (in_ready=0).
  - out_ready held low: full stall, no state change, no input accepted.
  - stage_width=1: each row outputs 2 pixels, out_last on the second.
  - Reset mid-frame: immediate return to IDLE with reset outputs; any partial frame is discarded.

Decomposition:
- Shared package (e.g. unet_accel_pkg): state encoding constants (IDLE=0, ROW_A=1, ROW_B=2, DONE=3) and the 8-bit pixel width constant, shared with the other accelerator blocks.
- Natural sub-module: upsample_linebuf, IMAGE_WIDTH x 8 register array.
  - One synchronous write port.
  - One asynchronous read port.
  - No reset on its contents.

Test Plan:
- 2x2 frame [10,20 / 30,40], out_ready=1, inputs back-to-back:
  - Output rows 10,10,20,20 | 10,10,20,20 | 30,30,40,40 | 30,30,40,40.
  - out_last on every 4th pixel.
  - frame_done a single pulse after the 16th transfer.
- Same frame with out_ready toggling 1,0,0,1,...:
  - Identical sequence.
  - pixel_out stable during stalls; no input accepted while the slot is full.
- stage_width=1, stage_height=3, inputs 5,6,7:
  - Output 5,5,5,5,6,6,6,6,7,7,7,7.
  - out_last every 2nd pixel.
- Reset asserted midway through ROW_B of a 4x4 frame:
  - Outputs zero immediately, state IDLE.
  - A new 2x2 frame after release produces a correct 16-pixel output.
- start pulsed while busy, and start with stage_width=0:
  - Both ignored: busy unchanged, no in_ready, no frame_done.
- stage_width=128, stage_height=2, ramp 0..255:
  - Output rows of 256 pixels.
  - Replayed rows match the line buffer exactly.
